psram_arbiter: RTL and testbench
================================

Name: psram_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the PSRAM (CellularRAM) controller.
- Port 1 is the video pipeline, which has high priority and issues read bursts. Port 2 is the picoBlaze interface logic, which issues reads and writes.
- Grants one complete operation at a time and routes controller status back to the winner only.
- Starvation guard and begin-timeout watchdog included.

Parameters:
- ADDR_W, 23, memory address width
- DATA_W, 16, memory data width
- STARVE_LIMIT, 4, consecutive port-1 grants while port 2 is pending before port 2 is forced to win
- TIMEOUT, 255, cycles in ISSUE without op_begun before the grant is aborted (8-bit counter)

Ports:
- clk  in  1  100MHz system clock (controller app_clk_100)
- reset  in  1  asynchronous, active-low reset
- ctrlr_good  in  1  controller ready for operation
- app_1_wr, app_1_rd, app_1_ub, app_1_lb, app_1_burst  in  1 each  port-1 strobes/qualifiers
- app_1_addr  in  ADDR_W  port-1 address
- app_1_data_wr  in  DATA_W  port-1 write data
- app_2_wr, app_2_rd, app_2_ub, app_2_lb, app_2_burst  in  1 each  port-2 strobes/qualifiers
- app_2_addr  in  ADDR_W  port-2 address
- app_2_data_wr  in  DATA_W  port-2 write data
- op_begun, data_ok, op_finished  in  1 each  controller status pulses
- app_wr, app_rd, app_ub, app_lb, app_burst  out  1 each  to controller
- app_addr  out  ADDR_W  to controller
- app_data_out  out  DATA_W  to controller
- app_1_op_begun, app_1_data_ok, app_1_op_finished  out  1 each  routed status, port 1
- app_2_op_begun, app_2_data_ok, app_2_op_finished  out  1 each  routed status, port 2
- arb_err  out  1  sticky: a begin-timeout occurred

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, grant=NONE, starve_cnt=0, timeout counter=0, arb_err=0.
  - All app_* outputs to the controller are 0.
  - All routed status outputs are 0.
- Requester protocol:
  - Request = wr|rd.
  - Requester holds strobes, addr, ub, lb and burst stable until its app_n_op_begun pulse.
  - If wr and rd are both high, wr wins and rd is not forwarded.
- IDLE:
  - No grant while ctrlr_good=0 or no request.
  - Winner rule: port 1, unless port 2 is pending and starve_cnt==STARVE_LIMIT.
  - Register grant, wr/rd, ub, lb, burst and addr from the winner; go to ISSUE.
  - Latency: request visible at edge t, app_wr/app_rd high after edge t+1.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, when port 1 is granted while port 2 is pending.
  - Clears to 0 when port 2 is granted.
  - Unchanged otherwise.
- ISSUE:
  - Registered strobes held until op_begun.
  - On op_begun: strobes are cleared at the next edge; go to ACTIVE.
  - If op_finished is also high that cycle, go straight to IDLE.
  - Timeout counter counts cycles in ISSUE. When it reaches TIMEOUT: clear strobes, grant=NONE, arb_err=1, return to IDLE. No status pulse is given to the requester.
- ACTIVE:
  - Wait for op_finished, then go to IDLE with grant=NONE.
  - One IDLE cycle minimum between operations.
  - ctrlr_good falling mid-operation does not abort the operation.
- Status routing (combinational, same cycle, gated by the grant register):
  - app_n_op_begun = op_begun & (grant==n), valid in ISSUE.
  - app_n_data_ok = data_ok & (grant==n).
  - app_n_op_finished = op_finished & (grant==n).
  - With grant=NONE, controller status is dropped.
- app_data_out:
  - Combinational mux of the granted port's data_wr, so burst writes can stream.
  - 0 when grant=NONE.
- app_addr, ub, lb and burst stay at the captured values until the next grant.
- arb_err clears only on reset.

Test Plan:
- Port-2 single write, addr=0x000123, data=0xBEEF, ctrlr_good=1:
  - app_wr and app_addr=0x000123 appear 1 cycle after the request.
  - app_data_out=0xBEEF.
  - app_2_op_begun and app_2_op_finished pulse once each; port-1 outputs stay 0.
- Both ports request a read in the same cycle:
  - Port 1 wins; app_1_op_begun pulses.
  - The 4 data_ok pulses route only to app_1_data_ok.
  - Port 2 is granted after op_finished plus one IDLE cycle.
- Port 1 requests back-to-back while port 2 is held pending:
  - Port 1 gets exactly 4 grants; the 5th grant goes to port 2.
  - starve_cnt then returns to 0.
- Controller never asserts op_begun:
  - After 255 cycles in ISSUE, app_rd drops and arb_err=1.
  - A new port-2 request is then served normally, with arb_err remaining 1.
- reset pulled low during ACTIVE:
  - All outputs go to 0 immediately, asynchronously.
  - After release, ctrlr_good=0 blocks grants; asserting ctrlr_good lets the pending request proceed.

Source files
------------

// File: rtl/psram_arbiter.sv
// psram_arbiter: two-port arbiter and sequencer in front of the PSRAM controller.
//   Port 1 (video, read bursts) has priority. Port 2 (picoBlaze) wins when it
//   has been passed over STARVE_LIMIT times in a row. One operation at a time;
//   controller status is routed only to the granted port. A grant that sees no
//   op_begun for TIMEOUT cycles is dropped and arb_err latches.
// Ports:
//   clk, reset (async, active-low), ctrlr_good
//   app_1_* / app_2_*        requester strobes, qualifiers, address, write data
//   op_begun/data_ok/op_finished  controller status pulses
//   app_wr/rd/ub/lb/burst/addr    registered command to the controller
//   app_data_out                  granted port's write data (combinational)
//   app_n_op_begun/data_ok/op_finished  routed status
//   arb_err                       sticky begin-timeout flag
//
// state  | meaning
// IDLE   | no grant; pick a winner when ctrlr_good and a request is present
// ISSUE  | command presented, waiting for op_begun (timeout running)
// ACTIVE | operation in flight, waiting for op_finished
module psram_arbiter #(
  parameter int ADDR_W       = 23,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ctrlr_good,
  input  logic              app_1_wr,
  input  logic              app_1_rd,
  input  logic              app_1_ub,
  input  logic              app_1_lb,
  input  logic              app_1_burst,
  input  logic [ADDR_W-1:0] app_1_addr,
  input  logic [DATA_W-1:0] app_1_data_wr,
  input  logic              app_2_wr,
  input  logic              app_2_rd,
  input  logic              app_2_ub,
  input  logic              app_2_lb,
  input  logic              app_2_burst,
  input  logic [ADDR_W-1:0] app_2_addr,
  input  logic [DATA_W-1:0] app_2_data_wr,
  input  logic              op_begun,
  input  logic              data_ok,
  input  logic              op_finished,
  output logic              app_wr,
  output logic              app_rd,
  output logic              app_ub,
  output logic              app_lb,
  output logic              app_burst,
  output logic [ADDR_W-1:0] app_addr,
  output logic [DATA_W-1:0] app_data_out,
  output logic              app_1_op_begun,
  output logic              app_1_data_ok,
  output logic              app_1_op_finished,
  output logic              app_2_op_begun,
  output logic              app_2_data_ok,
  output logic              app_2_op_finished,
  output logic              arb_err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_ACTIVE} state_t;
  typedef enum logic [1:0] {G_NONE, G_P1, G_P2} grant_t;

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  // Loaded on grant; abort fires when it has run down to zero, which gives
  // exactly TIMEOUT cycles of strobe in ISSUE.
  localparam logic [7:0]    TMO_LOAD   = 8'(TIMEOUT - 1);

  state_t          state;
  grant_t          grant;
  logic [SW-1:0]   starve_cnt;
  logic [7:0]      tmo_cnt;
  logic            req_1;
  logic            req_2;
  logic            pick_2;

  assign req_1  = app_1_wr | app_1_rd;
  assign req_2  = app_2_wr | app_2_rd;
  assign pick_2 = req_2 & (~req_1 | (starve_cnt == STARVE_MAX));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      grant      <= G_NONE;
      starve_cnt <= '0;
      tmo_cnt    <= '0;
      arb_err    <= 1'b0;
      app_wr     <= 1'b0;
      app_rd     <= 1'b0;
      app_ub     <= 1'b0;
      app_lb     <= 1'b0;
      app_burst  <= 1'b0;
      app_addr   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ctrlr_good && (req_1 || req_2)) begin
            state   <= S_ISSUE;
            tmo_cnt <= TMO_LOAD;
            if (pick_2) begin
              grant      <= G_P2;
              app_wr     <= app_2_wr;
              app_rd     <= app_2_rd & ~app_2_wr;
              app_ub     <= app_2_ub;
              app_lb     <= app_2_lb;
              app_burst  <= app_2_burst;
              app_addr   <= app_2_addr;
              starve_cnt <= '0;
            end else begin
              grant      <= G_P1;
              app_wr     <= app_1_wr;
              app_rd     <= app_1_rd & ~app_1_wr;
              app_ub     <= app_1_ub;
              app_lb     <= app_1_lb;
              app_burst  <= app_1_burst;
              app_addr   <= app_1_addr;
              if (req_2 && (starve_cnt != STARVE_MAX))
                starve_cnt <= starve_cnt + SW'(1);
            end
          end
        end
        S_ISSUE: begin
          // op_begun takes precedence over a timeout landing on the same cycle
          if (op_begun) begin
            app_wr <= 1'b0;
            app_rd <= 1'b0;
            if (op_finished) begin
              state <= S_IDLE;
              grant <= G_NONE;
            end else begin
              state <= S_ACTIVE;
            end
          end else if (tmo_cnt == 8'd0) begin
            app_wr  <= 1'b0;
            app_rd  <= 1'b0;
            grant   <= G_NONE;
            arb_err <= 1'b1;
            state   <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt - 8'd1;
          end
        end
        S_ACTIVE: begin
          if (op_finished) begin
            state <= S_IDLE;
            grant <= G_NONE;
          end
        end
        default: begin
          state <= S_IDLE;
          grant <= G_NONE;
        end
      endcase
    end
  end

  always_comb begin
    app_data_out = '0;
    case (grant)
      G_P1:    app_data_out = app_1_data_wr;
      G_P2:    app_data_out = app_2_data_wr;
      default: app_data_out = '0;
    endcase
  end

  assign app_1_op_begun    = op_begun    & (grant == G_P1);
  assign app_1_data_ok     = data_ok     & (grant == G_P1);
  assign app_1_op_finished = op_finished & (grant == G_P1);
  assign app_2_op_begun    = op_begun    & (grant == G_P2);
  assign app_2_data_ok     = data_ok     & (grant == G_P2);
  assign app_2_op_finished = op_finished & (grant == G_P2);

endmodule

// File: tb/tb_psram_arbiter.sv
module tb_psram_arbiter;

  localparam int ADDR_W = 23;
  localparam int DATA_W = 16;
  localparam logic [ADDR_W-1:0] A1 = 23'h0ABCDE;
  localparam logic [ADDR_W-1:0] A2 = 23'h000123;

  logic clk, reset, ctrlr_good;
  logic app_1_wr, app_1_rd, app_1_ub, app_1_lb, app_1_burst;
  logic [ADDR_W-1:0] app_1_addr;
  logic [DATA_W-1:0] app_1_data_wr;
  logic app_2_wr, app_2_rd, app_2_ub, app_2_lb, app_2_burst;
  logic [ADDR_W-1:0] app_2_addr;
  logic [DATA_W-1:0] app_2_data_wr;
  logic op_begun, data_ok, op_finished;
  logic app_wr, app_rd, app_ub, app_lb, app_burst;
  logic [ADDR_W-1:0] app_addr;
  logic [DATA_W-1:0] app_data_out;
  logic app_1_op_begun, app_1_data_ok, app_1_op_finished;
  logic app_2_op_begun, app_2_data_ok, app_2_op_finished;
  logic arb_err;

  int checks = 0;
  int errors = 0;

  psram_arbiter dut (
    .clk(clk), .reset(reset), .ctrlr_good(ctrlr_good),
    .app_1_wr(app_1_wr), .app_1_rd(app_1_rd), .app_1_ub(app_1_ub), .app_1_lb(app_1_lb),
    .app_1_burst(app_1_burst), .app_1_addr(app_1_addr), .app_1_data_wr(app_1_data_wr),
    .app_2_wr(app_2_wr), .app_2_rd(app_2_rd), .app_2_ub(app_2_ub), .app_2_lb(app_2_lb),
    .app_2_burst(app_2_burst), .app_2_addr(app_2_addr), .app_2_data_wr(app_2_data_wr),
    .op_begun(op_begun), .data_ok(data_ok), .op_finished(op_finished),
    .app_wr(app_wr), .app_rd(app_rd), .app_ub(app_ub), .app_lb(app_lb), .app_burst(app_burst),
    .app_addr(app_addr), .app_data_out(app_data_out),
    .app_1_op_begun(app_1_op_begun), .app_1_data_ok(app_1_data_ok),
    .app_1_op_finished(app_1_op_finished),
    .app_2_op_begun(app_2_op_begun), .app_2_data_ok(app_2_data_ok),
    .app_2_op_finished(app_2_op_finished),
    .arb_err(arb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; ctrlr_good = 1'b0;
    app_1_wr = 0; app_1_rd = 0; app_1_ub = 0; app_1_lb = 0; app_1_burst = 0;
    app_1_addr = A1; app_1_data_wr = 16'h1111;
    app_2_wr = 0; app_2_rd = 0; app_2_ub = 0; app_2_lb = 0; app_2_burst = 0;
    app_2_addr = A2; app_2_data_wr = 16'hBEEF;
    op_begun = 0; data_ok = 0; op_finished = 0;
    tick(); tick();
    checks++;
    if ({app_wr, app_rd, app_ub, app_lb, app_burst, arb_err} !== 6'b0 ||
        app_addr !== '0 || app_data_out !== '0) begin
      errors++;
      $display("FAIL reset_outputs got wr=%b rd=%b addr=%h data=%h err=%b exp all 0",
               app_wr, app_rd, app_addr, app_data_out, arb_err);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_p2_write();
    ctrlr_good = 1'b1;
    app_2_wr = 1; app_2_ub = 1; app_2_lb = 1;
    #1;
    checks++;
    if (app_wr !== 1'b0) begin errors++; $display("FAIL p2wr_not_early got %b exp 0", app_wr); end
    tick();
    checks++;
    if (app_wr !== 1'b1 || app_rd !== 1'b0 || app_addr !== A2 || app_ub !== 1'b1 || app_lb !== 1'b1) begin
      errors++;
      $display("FAIL p2wr_cmd got wr=%b rd=%b addr=%h ub=%b lb=%b exp wr=1 rd=0 addr=%h ub=1 lb=1",
               app_wr, app_rd, app_addr, app_ub, app_lb, A2);
    end
    checks++;
    if (app_data_out !== 16'hBEEF) begin errors++; $display("FAIL p2wr_data got %h exp beef", app_data_out); end
    op_begun = 1; #1;
    checks++;
    if (app_2_op_begun !== 1'b1 || app_1_op_begun !== 1'b0) begin
      errors++; $display("FAIL p2wr_begun got p1=%b p2=%b exp p1=0 p2=1", app_1_op_begun, app_2_op_begun);
    end
    tick();
    op_begun = 0; app_2_wr = 0;
    #1;
    checks++;
    if (app_wr !== 1'b0 || app_2_op_begun !== 1'b0) begin
      errors++; $display("FAIL p2wr_strobe_clear got wr=%b begun=%b exp 0 0", app_wr, app_2_op_begun);
    end
    op_finished = 1; #1;
    checks++;
    if (app_2_op_finished !== 1'b1 || app_1_op_finished !== 1'b0) begin
      errors++; $display("FAIL p2wr_finished got p1=%b p2=%b exp p1=0 p2=1", app_1_op_finished, app_2_op_finished);
    end
    tick();
    op_finished = 0; #1;
    checks++;
    if (app_data_out !== '0 || app_addr !== A2) begin
      errors++; $display("FAIL p2wr_idle got data=%h addr=%h exp data=0 addr=%h", app_data_out, app_addr, A2);
    end
    app_2_ub = 0; app_2_lb = 0;
  endtask

  task automatic test_both_read();
    int ok_cnt;
    app_1_rd = 1; app_1_burst = 1; app_2_rd = 1;
    tick();
    checks++;
    if (app_rd !== 1'b1 || app_addr !== A1 || app_burst !== 1'b1 || app_data_out !== 16'h1111) begin
      errors++; $display("FAIL both_p1_wins got rd=%b addr=%h burst=%b data=%h exp 1 %h 1 1111",
                         app_rd, app_addr, app_burst, app_data_out, A1);
    end
    op_begun = 1; #1;
    checks++;
    if (app_1_op_begun !== 1'b1 || app_2_op_begun !== 1'b0) begin
      errors++; $display("FAIL both_begun got p1=%b p2=%b exp 1 0", app_1_op_begun, app_2_op_begun);
    end
    tick();
    op_begun = 0; app_1_rd = 0; app_1_burst = 0;
    ctrlr_good = 0;  // must not abort an operation already in flight
    ok_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      data_ok = 1; #1;
      if (app_1_data_ok === 1'b1 && app_2_data_ok === 1'b0) ok_cnt++;
      tick();
      data_ok = 0;
    end
    checks++;
    if (ok_cnt !== 4) begin errors++; $display("FAIL both_data_ok_route got %0d exp 4", ok_cnt); end
    ctrlr_good = 1;
    op_finished = 1; #1;
    checks++;
    if (app_1_op_finished !== 1'b1 || app_2_op_finished !== 1'b0) begin
      errors++; $display("FAIL both_finished got p1=%b p2=%b exp 1 0", app_1_op_finished, app_2_op_finished);
    end
    tick();
    op_finished = 0; #1;
    checks++;
    if (app_rd !== 1'b0) begin errors++; $display("FAIL both_idle_gap got rd=%b exp 0", app_rd); end
    tick();
    checks++;
    if (app_rd !== 1'b1 || app_addr !== A2) begin
      errors++; $display("FAIL both_p2_next got rd=%b addr=%h exp 1 %h", app_rd, app_addr, A2);
    end
    op_begun = 1; op_finished = 1; #1;
    checks++;
    if (app_2_op_begun !== 1'b1 || app_2_op_finished !== 1'b1) begin
      errors++; $display("FAIL both_p2_short got begun=%b fin=%b exp 1 1", app_2_op_begun, app_2_op_finished);
    end
    tick();
    op_begun = 0; op_finished = 0; app_2_rd = 0;
    #1;
    checks++;
    if (app_rd !== 1'b0) begin errors++; $display("FAIL both_p2_done got rd=%b exp 0", app_rd); end
  endtask

  task automatic test_starvation();
    int exp_port;
    int bad;
    bad = 0;
    app_1_rd = 1; app_2_rd = 1;
    for (int i = 0; i < 10; i++) begin
      exp_port = (i % 5 == 4) ? 2 : 1;
      tick();
      op_begun = 1; op_finished = 1; #1;
      checks++;
      if (app_rd !== 1'b1 || app_addr !== ((exp_port == 1) ? A1 : A2) ||
          app_1_op_begun !== (exp_port == 1) || app_2_op_begun !== (exp_port == 2)) begin
        errors++; bad++;
        $display("FAIL starve_grant_%0d got rd=%b addr=%h b1=%b b2=%b exp port %0d",
                 i, app_rd, app_addr, app_1_op_begun, app_2_op_begun, exp_port);
      end
      tick();
      op_begun = 0; op_finished = 0;
    end
    app_1_rd = 0; app_2_rd = 0;
    tick();
  endtask

  task automatic test_timeout();
    int cyc;
    app_1_rd = 1;
    tick();
    checks++;
    if (app_rd !== 1'b1 || arb_err !== 1'b0) begin
      errors++; $display("FAIL tmo_grant got rd=%b err=%b exp 1 0", app_rd, arb_err);
    end
    cyc = 0;
    while (app_rd === 1'b1 && cyc < 300) begin
      tick();
      cyc++;
    end
    app_1_rd = 0;
    checks++;
    if (cyc !== 255) begin errors++; $display("FAIL tmo_cycles got %0d exp 255", cyc); end
    checks++;
    if (arb_err !== 1'b1 || app_1_op_begun !== 1'b0) begin
      errors++; $display("FAIL tmo_err got err=%b begun=%b exp 1 0", arb_err, app_1_op_begun);
    end
    // wr and rd together: write wins
    app_2_wr = 1; app_2_rd = 1;
    tick();
    checks++;
    if (app_wr !== 1'b1 || app_rd !== 1'b0 || app_addr !== A2 || app_data_out !== 16'hBEEF) begin
      errors++; $display("FAIL tmo_p2_cmd got wr=%b rd=%b addr=%h data=%h exp 1 0 %h beef",
                         app_wr, app_rd, app_addr, app_data_out, A2);
    end
    op_begun = 1; #1;
    checks++;
    if (app_2_op_begun !== 1'b1) begin errors++; $display("FAIL tmo_p2_begun got %b exp 1", app_2_op_begun); end
    tick();
    op_begun = 0; app_2_wr = 0; app_2_rd = 0;
    op_finished = 1; #1;
    checks++;
    if (app_2_op_finished !== 1'b1 || arb_err !== 1'b1) begin
      errors++; $display("FAIL tmo_p2_fin got fin=%b err=%b exp 1 1", app_2_op_finished, arb_err);
    end
    tick();
    op_finished = 0;
  endtask

  task automatic test_async_reset();
    app_1_rd = 1; app_1_burst = 1;
    tick();
    op_begun = 1;
    tick();
    op_begun = 0; app_1_rd = 0; app_1_burst = 0;
    data_ok = 1; #1;
    checks++;
    if (app_1_data_ok !== 1'b1 || app_burst !== 1'b1) begin
      errors++; $display("FAIL rst_active_pre got ok=%b burst=%b exp 1 1", app_1_data_ok, app_burst);
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if (app_1_data_ok !== 1'b0 || app_burst !== 1'b0 || app_addr !== '0 ||
        app_data_out !== '0 || arb_err !== 1'b0 || app_rd !== 1'b0) begin
      errors++; $display("FAIL rst_async got ok=%b burst=%b addr=%h data=%h err=%b rd=%b exp all 0",
                         app_1_data_ok, app_burst, app_addr, app_data_out, arb_err, app_rd);
    end
    data_ok = 0;
    tick();
    ctrlr_good = 0; app_2_rd = 1;
    reset = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (app_rd !== 1'b0) begin errors++; $display("FAIL rst_good_block got rd=%b exp 0", app_rd); end
    ctrlr_good = 1;
    tick();
    checks++;
    if (app_rd !== 1'b1 || app_addr !== A2) begin
      errors++; $display("FAIL rst_good_go got rd=%b addr=%h exp 1 %h", app_rd, app_addr, A2);
    end
    app_2_rd = 0;
  endtask

  initial begin
    reset = 1'b0;
    test_reset();
    test_p2_write();
    test_both_read();
    test_starvation();
    test_timeout();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
